multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences PC, instruction register, memory, ALU and register file over 3–5 cycles per instruction.
- Drives the immediate-extender select (ImmSrc) and the ALU operation.
- Supports lw, sw, R-type ALU, I-type ALU and beq. Stalls fetch and data accesses on a memory-ready handshake.

---
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I core: lw, sw, R/I-type ALU and beq.
// Optional feature: define ILLEGAL_TRAP_EN to add the Illegal port and a sticky TRAP state.
module multicycle_controller #(
   parameter int ALUCTRL_W = 3,
   parameter int STATE_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           Op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 Zero,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [1:0]           ImmSrc,
   output logic [STATE_W-1:0]   State
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                 Illegal
`endif
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(5);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECR    = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_EXECI    = STATE_W'(8),
      S_BEQ      = STATE_W'(10)
`ifdef ILLEGAL_TRAP_EN
      ,
      S_TRAP     = STATE_W'(15)
`endif
   } state_t;

   state_t                 state_reg;
   logic [ALUCTRL_W-1:0]   alu_fn;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_FETCH;
      end else begin
         case (state_reg)
            S_FETCH:    if (MemReady) state_reg <= S_DECODE;
            S_DECODE: begin
               case (Op)
                  OP_LW, OP_SW: state_reg <= S_MEMADR;
                  OP_RTYP:      state_reg <= S_EXECR;
                  OP_ITYP:      state_reg <= S_EXECI;
                  OP_BEQ:       state_reg <= S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                  default:      state_reg <= S_TRAP;
`else
                  default:      state_reg <= S_FETCH;
`endif
               endcase
            end
            // Op[5] separates sw (0100011) from lw (0000011).
            S_MEMADR:   state_reg <= Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_reg <= S_MEMWB;
            S_MEMWB:    state_reg <= S_FETCH;
            S_MEMWRITE: if (MemReady) state_reg <= S_FETCH;
            S_EXECR:    state_reg <= S_ALUWB;
            S_EXECI:    state_reg <= S_ALUWB;
            S_ALUWB:    state_reg <= S_FETCH;
            S_BEQ:      state_reg <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_reg <= S_TRAP;
`endif
            default:    state_reg <= S_FETCH;
         endcase
      end
   end

   // Subtract only for R-type with funct7[5] set; I-type addi never subtracts.
   always_comb begin
      alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  alu_fn = (Op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_fn = ALU_SLT;
         3'b110:  alu_fn = ALU_OR;
         3'b111:  alu_fn = ALU_AND;
         default: alu_fn = ALU_ADD;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
      Illegal    = 1'b0;
`endif
      case (state_reg)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_fn;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_fn;
         end
         S_ALUWB: RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            PCWrite    = Zero;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: Illegal = 1'b1;
`endif
         default: ;
      endcase
      // FETCH would otherwise follow MemReady while reset holds the state.
      if (!rst) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign State = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, corner sequences, random instruction stream.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] Op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;
`ifdef ILLEGAL_TRAP_EN
   logic       Illegal;
`endif

   multicycle_controller #(.ALUCTRL_W(3), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .State(State)
`ifdef ILLEGAL_TRAP_EN
      , .Illegal(Illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, memw, irw, regw;
      logic [1:0] res, sa, sb;
      logic [2:0] alu;
      logic [1:0] imm;
   } ctl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       zr;
      int         fwait;
      int         mwait;
      int         cycles;
      logic [2:0] alu3;
      int         memw;
      int         regw;
      logic [1:0] imm;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc_cnt, memw_cnt, regw_cnt, alu_idx;
   logic [2:0] alu_obs;
   vec_t vec[14];

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      if (op == OP_SW) return 2'b01;
      if (op == OP_BEQ) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [2:0] model_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (f3 == 3'b000) return (op == OP_R && f7) ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      return 3'b000;
   endfunction

   function automatic ctl_t ex(input logic [3:0] st, input logic pcw, adr, memw, irw, regw,
                               input logic [1:0] res, sa, sb, input logic [2:0] alu);
      return {st, pcw, adr, memw, irw, regw, res, sa, sb, alu, imm_of(Op)};
   endfunction

   // One clock: drive inputs, compare all outputs mid-cycle, advance past the edge.
   task automatic step(input logic mr, input logic zr, input ctl_t exp);
      ctl_t act;
      MemReady = mr;
      Zero = zr;
      @(negedge clk);
      act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
      cyc_cnt++;
      if (cyc_cnt == alu_idx) alu_obs = ALUControl;
      if (MemWrite) memw_cnt++;
      if (RegWrite) regw_cnt++;
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL cycle_outputs op=%b cyc=%0d got=%h want=%h", Op, cyc_cnt, act, exp);
      end
`ifdef ILLEGAL_TRAP_EN
      checks++;
      if (Illegal !== (exp.st == 4'd15)) begin
         failures++;
         $display("FAIL illegal_flag cyc=%0d got=%b want=%b", cyc_cnt, Illegal, exp.st == 4'd15);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_quiet(input int tag);
      checks++;
      if ({State, PCWrite, MemWrite, IRWrite, RegWrite} !== 8'h00) begin
         failures++;
         $display("FAIL reset_quiet tag=%0d got state=%0d pcw=%b memw=%b irw=%b regw=%b want 0", tag,
                  State, PCWrite, MemWrite, IRWrite, RegWrite);
      end
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic zr, input int fwait, input int mwait);
      logic [2:0] fn;
      Op = op;
      funct3 = f3;
      funct7b5 = f7;
      cyc_cnt = 0;
      memw_cnt = 0;
      regw_cnt = 0;
      alu_obs = 3'b000;
      alu_idx = fwait + 3;
      fn = model_alu(op, f3, f7);
      for (int i = 0; i < fwait; i++) step(1'b0, rnd(), ex(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0));
      step(1'b1, rnd(), ex(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0));
      step(rnd(), rnd(), ex(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0));
      if (op == OP_LW || op == OP_SW) begin
         step(rnd(), rnd(), ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0));
         for (int i = 0; i <= mwait; i++) begin
            if (op == OP_LW) step(i == mwait, rnd(), ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0));
            else             step(i == mwait, rnd(), ex(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0));
         end
         if (op == OP_LW) step(rnd(), rnd(), ex(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0));
      end else if (op == OP_R || op == OP_I) begin
         step(rnd(), rnd(), ex(op == OP_R ? 4'd6 : 4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                               op == OP_R ? 2'b00 : 2'b01, fn));
         step(rnd(), rnd(), ex(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0));
      end else if (op == OP_BEQ) begin
         step(rnd(), zr, ex(4'd10, zr, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1));
      end else begin
`ifdef ILLEGAL_TRAP_EN
         for (int i = 0; i < 3; i++) step(rnd(), rnd(), ex(4'd15, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0));
         MemReady = 1'b0;
         #2 rst = 1'b0;
         #1 check_reset_quiet(2);
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1;
`endif
      end
      $display("instr op=%b f3=%b f7=%b zero=%b fwait=%0d mwait=%0d cycles=%0d", op, f3, f7, zr,
               fwait, mwait, cyc_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 0, 0, 5, 3'b000, 0, 1, 2'b00};
      vec[1]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 0, 2, 7, 3'b000, 0, 1, 2'b00};
      vec[2]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 2, 1, 8, 3'b000, 0, 1, 2'b00};
      vec[3]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 0, 0, 4, 3'b000, 1, 0, 2'b01};
      vec[4]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 0, 3, 7, 3'b000, 4, 0, 2'b01};
      vec[5]  = '{OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 4, 3'b001, 0, 1, 2'b00};
      vec[6]  = '{OP_I,   3'b000, 1'b1, 1'b0, 0, 0, 4, 3'b000, 0, 1, 2'b00};
      vec[7]  = '{OP_R,   3'b111, 1'b0, 1'b0, 0, 0, 4, 3'b010, 0, 1, 2'b00};
      vec[8]  = '{OP_R,   3'b110, 1'b0, 1'b0, 0, 0, 4, 3'b011, 0, 1, 2'b00};
      vec[9]  = '{OP_I,   3'b010, 1'b0, 1'b0, 0, 0, 4, 3'b101, 0, 1, 2'b00};
      vec[10] = '{OP_R,   3'b100, 1'b1, 1'b0, 0, 0, 4, 3'b000, 0, 1, 2'b00};
      vec[11] = '{OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 3, 3'b001, 0, 0, 2'b10};
      vec[12] = '{OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 3, 3'b001, 0, 0, 2'b10};
      vec[13] = '{OP_BEQ, 3'b000, 1'b1, 1'b1, 1, 0, 4, 3'b001, 0, 0, 2'b10};

      // Reset held with MemReady high: FETCH strobes must stay quiet.
      repeat (2) @(posedge clk);
      #1;
      MemReady = 1'b1;
      #1 check_reset_quiet(0);
      @(negedge clk);
      MemReady = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vec[k]) begin
         run_instr(vec[k].op, vec[k].f3, vec[k].f7, vec[k].zr, vec[k].fwait, vec[k].mwait);
         checks++;
         if (cyc_cnt != vec[k].cycles) begin
            failures++;
            $display("FAIL vec%0d_cycles got=%0d want=%0d", k, cyc_cnt, vec[k].cycles);
         end
         checks++;
         if (alu_obs !== vec[k].alu3) begin
            failures++;
            $display("FAIL vec%0d_aluctl got=%b want=%b", k, alu_obs, vec[k].alu3);
         end
         checks++;
         if (memw_cnt != vec[k].memw || regw_cnt != vec[k].regw) begin
            failures++;
            $display("FAIL vec%0d_strobes got memw=%0d regw=%0d want memw=%0d regw=%0d", k,
                     memw_cnt, regw_cnt, vec[k].memw, vec[k].regw);
         end
         checks++;
         if (ImmSrc !== vec[k].imm) begin
            failures++;
            $display("FAIL vec%0d_immsrc got=%b want=%b", k, ImmSrc, vec[k].imm);
         end
      end

      // Reset asserted mid-MEMREAD, then released with MemReady high.
      Op = OP_LW;
      funct3 = 3'b010;
      funct7b5 = 1'b0;
      cyc_cnt = 0;
      alu_idx = 0;
      step(1'b1, 1'b0, ex(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0));
      step(1'b0, 1'b0, ex(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0));
      step(1'b0, 1'b0, ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0));
      step(1'b0, 1'b0, ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0));
      MemReady = 1'b1;
      #2 rst = 1'b0;
      #1 check_reset_quiet(1);
      @(posedge clk);
      #1 check_reset_quiet(3);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({State, IRWrite, PCWrite, MemWrite, RegWrite} !== {4'd0, 4'b1100}) begin
         failures++;
         $display("FAIL reset_release got state=%0d irw=%b pcw=%b want state=0 irw=1 pcw=1", State,
                  IRWrite, PCWrite);
      end
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, ex(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0));
      step(1'b1, 1'b0, ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0));
      step(1'b1, 1'b0, ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0));
      step(1'b1, 1'b0, ex(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0));

      // Unsupported opcode: NOP back to FETCH, or TRAP until reset.
      run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
      checks++;
      if (cyc_cnt != 2 || memw_cnt != 0 || regw_cnt != 0) begin
         failures++;
         $display("FAIL illegal_nop got cycles=%0d memw=%0d regw=%0d want 2/0/0", cyc_cnt, memw_cnt, regw_cnt);
      end
`endif

      for (int n = 0; n < 150; n++) begin
         logic [6:0] op;
         case ($urandom_range(0, 5))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_I;
            4: op = OP_BEQ;
            default: op = OP_BAD;
         endcase
         run_instr(op, 3'($urandom_range(0, 7)), rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
      end
      step(1'b0, 1'b0, ex(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
